// File: rtl/io_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// io_ctrl_pkg: register map, status bit positions and 7-seg helpers for io_ctrl.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package io_ctrl_pkg;

  localparam int REG_LEDS     = 0;
  localparam int REG_SW       = 1;
  localparam int REG_TIMER    = 2;
  localparam int REG_TCMP     = 3;
  localparam int REG_STATUS   = 4;
  localparam int REG_IRQ_EN   = 5;
  localparam int REG_SEG_BASE = 8;

  localparam int ST_TMATCH_BIT = 0;
  localparam int ST_SWCHG_LSB  = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, {A,B,C,D,E,F,G} with A in bit 6.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      default: s = 7'h38;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] wmask);
    return {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wmask);
    return (old_v & ~lane_mask(wmask)) | (wdata & lane_mask(wmask));
  endfunction

endpackage

`default_nettype wire

// File: rtl/io_debounce.sv
// ---------------------------------------------------------------------------
// io_debounce: 2-flop synchroniser plus stable-count debouncer for one switch.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw,
  output logic state,
  output logic changed
);

  localparam int               CNT_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             state_q, state_d;
  logic             chg_q,   chg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
    state_d = state_q;
    chg_d   = 1'b0;
    cnt_d   = '0;
    // Any cycle agreeing with the accepted state drops the count back to zero.
    if (sync2_q != state_q) begin
      if (cnt_q == CNT_LAST) begin
        state_d = sync2_q;
        chg_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      chg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state   = state_q;
  assign changed = chg_q;

endmodule

`default_nettype wire

// File: rtl/io_ctrl.sv
// ---------------------------------------------------------------------------
// io_ctrl: memory-mapped LEDs, 7-seg digits, debounced switches, timer/compare.
// Optional macro IO_HEX_DECODE_EN adds per-digit hex decode mode. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module io_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int N_LEDS          = 4,
  parameter int N_DIGITS        = 2,
  parameter int N_SW            = 1,
  parameter int DEBOUNCE_CYCLES = 65535,
  parameter int TIMER_W         = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  io_sel,
  input  logic [5:0]            io_addr,
  input  logic [31:0]           io_wdata,
  input  logic [3:0]            io_wmask,
  input  logic                  io_rstrb,
  output logic [31:0]           io_rdata,
  input  logic [N_SW-1:0]       sw_in,
  output logic [N_LEDS-1:0]     leds,
  output logic [7*N_DIGITS-1:0] seg,
  output logic                  irq
);

  localparam int ST_W = ST_SWCHG_LSB + N_SW;
`ifdef IO_HEX_DECODE_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif
  localparam logic [SEG_W-1:0] SEG_RST = SEG_W'(SEG_BLANK);

  localparam logic [5:0] A_LEDS   = 6'(REG_LEDS);
  localparam logic [5:0] A_SW     = 6'(REG_SW);
  localparam logic [5:0] A_TIMER  = 6'(REG_TIMER);
  localparam logic [5:0] A_TCMP   = 6'(REG_TCMP);
  localparam logic [5:0] A_STATUS = 6'(REG_STATUS);
  localparam logic [5:0] A_IRQ_EN = 6'(REG_IRQ_EN);

  logic [N_LEDS-1:0]  leds_q,   leds_d;
  logic [TIMER_W-1:0] timer_q,  timer_d;
  logic [TIMER_W-1:0] tcmp_q,   tcmp_d;
  logic [ST_W-1:0]    status_q, status_d;
  logic [ST_W-1:0]    irq_en_q, irq_en_d;
  logic [SEG_W-1:0]   seg_q [N_DIGITS];
  logic [SEG_W-1:0]   seg_d [N_DIGITS];
  logic [31:0]        rdata_q,  rdata_d;
  logic               irq_q,    irq_d;

  logic [N_SW-1:0] sw_state;
  logic [N_SW-1:0] sw_chg;
  logic            wr_en;
  logic            rd_en;
  logic [31:0]     rd_val;
  logic [ST_W-1:0] st_set;
  logic [ST_W-1:0] st_clr;

  assign wr_en = io_sel & (|io_wmask);
  assign rd_en = io_sel & io_rstrb;

  generate
    for (genvar g = 0; g < N_SW; g++) begin : g_sw
      io_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .sw_raw (sw_in[g]),
        .state  (sw_state[g]),
        .changed(sw_chg[g])
      );
    end
  endgenerate

  // Read mux sees only pre-write register values, so a same-cycle write is not visible.
  always_comb begin
    rd_val = '0;
    case (io_addr)
      A_LEDS:   rd_val = 32'(leds_q);
      A_SW:     rd_val = 32'(sw_state);
      A_TIMER:  rd_val = 32'(timer_q);
      A_TCMP:   rd_val = 32'(tcmp_q);
      A_STATUS: rd_val = 32'(status_q);
      A_IRQ_EN: rd_val = 32'(irq_en_q);
      default:  ;
    endcase
    for (int i = 0; i < N_DIGITS; i++) begin
      if (io_addr == 6'(REG_SEG_BASE + i)) rd_val = 32'(seg_q[i]);
    end
  end

  always_comb begin
    leds_d   = leds_q;
    timer_d  = timer_q + TIMER_W'(1);
    tcmp_d   = tcmp_q;
    irq_en_d = irq_en_q;
    seg_d    = seg_q;
    st_clr   = '0;
    if (wr_en) begin
      case (io_addr)
        A_LEDS:   leds_d   = N_LEDS'(lane_merge(32'(leds_q), io_wdata, io_wmask));
        A_TIMER:  timer_d  = TIMER_W'(lane_merge(32'(timer_q), io_wdata, io_wmask));
        A_TCMP:   tcmp_d   = TIMER_W'(lane_merge(32'(tcmp_q), io_wdata, io_wmask));
        A_STATUS: st_clr   = ST_W'(io_wdata & lane_mask(io_wmask));
        A_IRQ_EN: irq_en_d = ST_W'(lane_merge(32'(irq_en_q), io_wdata, io_wmask));
        default:  ;
      endcase
      for (int i = 0; i < N_DIGITS; i++) begin
        if (io_addr == 6'(REG_SEG_BASE + i)) begin
          seg_d[i] = SEG_W'(lane_merge(32'(seg_q[i]), io_wdata, io_wmask));
        end
      end
    end
  end

  always_comb begin
    st_set                          = '0;
    st_set[ST_TMATCH_BIT]           = (timer_q == tcmp_q);
    st_set[ST_SWCHG_LSB +: N_SW]    = sw_chg;
    status_d = (status_q & ~st_clr) | st_set;
    irq_d    = |(status_q & irq_en_q);
    rdata_d  = rd_en ? rd_val : rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      leds_q   <= '0;
      timer_q  <= '0;
      tcmp_q   <= '1;
      status_q <= '0;
      irq_en_q <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) seg_q[i] <= SEG_RST;
    end else begin
      leds_q   <= leds_d;
      timer_q  <= timer_d;
      tcmp_q   <= tcmp_d;
      status_q <= status_d;
      irq_en_q <= irq_en_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
      for (int i = 0; i < N_DIGITS; i++) seg_q[i] <= seg_d[i];
    end
  end

  generate
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
`ifdef IO_HEX_DECODE_EN
      assign seg[7*g +: 7] = seg_q[g][7] ? hex_to_seg(seg_q[g][3:0]) : seg_q[g][6:0];
`else
      assign seg[7*g +: 7] = seg_q[g];
`endif
    end
  endgenerate

  assign leds     = leds_q;
  assign io_rdata = rdata_q;
  assign irq      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_io_ctrl: directed-vector bench with read-data scoreboard for io_ctrl.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_io_ctrl;

  localparam int N_LEDS   = 4;
  localparam int N_DIGITS = 2;
  localparam int N_SW     = 1;
  localparam int DEB      = 8;
  localparam int TIMER_W  = 8;

  localparam logic [5:0] A_LEDS   = 6'd0;
  localparam logic [5:0] A_SW     = 6'd1;
  localparam logic [5:0] A_TIMER  = 6'd2;
  localparam logic [5:0] A_TCMP   = 6'd3;
  localparam logic [5:0] A_STATUS = 6'd4;
  localparam logic [5:0] A_IRQ_EN = 6'd5;
  localparam logic [5:0] A_SEG0   = 6'd8;
  localparam logic [5:0] A_SEG1   = 6'd9;

  logic                  clk      = 1'b0;
  logic                  reset_n  = 1'b1;
  logic                  io_sel   = 1'b0;
  logic [5:0]            io_addr  = '0;
  logic [31:0]           io_wdata = '0;
  logic [3:0]            io_wmask = '0;
  logic                  io_rstrb = 1'b0;
  logic [31:0]           io_rdata;
  logic [N_SW-1:0]       sw_in    = '0;
  logic [N_LEDS-1:0]     leds;
  logic [7*N_DIGITS-1:0] seg;
  logic                  irq;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q  [$];
  logic [31:0] msk_q  [$];
  string       name_q [$];

  io_ctrl #(
    .N_LEDS         (N_LEDS),
    .N_DIGITS       (N_DIGITS),
    .N_SW           (N_SW),
    .DEBOUNCE_CYCLES(DEB),
    .TIMER_W        (TIMER_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io_sel  (io_sel),
    .io_addr (io_addr),
    .io_wdata(io_wdata),
    .io_wmask(io_wmask),
    .io_rstrb(io_rstrb),
    .io_rdata(io_rdata),
    .sw_in   (sw_in),
    .leds    (leds),
    .seg     (seg),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic op(input logic [5:0] addr, input logic [31:0] wd,
                    input logic [3:0] wm, input logic rs);
    @(negedge clk);
    io_sel   = 1'b1;
    io_addr  = addr;
    io_wdata = wd;
    io_wmask = wm;
    io_rstrb = rs;
    @(posedge clk);
    #1;
    io_sel   = 1'b0;
    io_wmask = '0;
    io_rstrb = 1'b0;
  endtask

  task automatic wr(input logic [5:0] addr, input logic [31:0] wd,
                    input logic [3:0] wm = 4'hF);
    op(addr, wd, wm, 1'b0);
  endtask

  task automatic expect_rd(input logic [31:0] exp, input string name,
                           input logic [31:0] msk);
    exp_q.push_back(exp);
    msk_q.push_back(msk);
    name_q.push_back(name);
  endtask

  task automatic rd(input logic [5:0] addr, input logic [31:0] exp,
                    input string name, input logic [31:0] msk = 32'hFFFF_FFFF);
    expect_rd(exp, name, msk);
    op(addr, 32'h0, 4'h0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every accepted read strobe must produce the next queued value.
  initial begin : monitor
    logic        strobe;
    logic [31:0] e;
    logic [31:0] m;
    string       n;
    forever begin
      @(posedge clk);
      strobe = io_sel && io_rstrb && reset_n;
      #1;
      if (strobe) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rdata_unexpected: got 0x%08h with no read queued", io_rdata);
        end else begin
          e = exp_q.pop_front();
          m = msk_q.pop_front();
          n = name_q.pop_front();
          check(n, io_rdata & m, e & m);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_leds",  32'(leds),     32'h0);
    check("rst_seg",   32'(seg),      32'h3FFF);
    check("rst_rdata", io_rdata,      32'h0);
    check("rst_irq",   32'(irq),      32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    rd(A_STATUS, 32'h0,   "rst_status");
    rd(A_TCMP,   32'hFF,  "rst_tcmp");
    rd(A_LEDS,   32'h0,   "rst_leds_rd");
    rd(A_SW,     32'h0,   "rst_sw");
    rd(A_IRQ_EN, 32'h0,   "rst_irq_en");
    rd(A_SEG0,   32'h7F,  "rst_seg0");
    rd(A_SEG1,   32'h7F,  "rst_seg1");

    // LEDS byte lanes and width truncation.
    wr(A_LEDS, 32'hFFFF_FFFF, 4'b0001);
    check("leds_lane0", 32'(leds), 32'hF);
    rd(A_LEDS, 32'hF, "leds_rd");
    wr(A_LEDS, 32'h0, 4'b0010);
    check("leds_lane1_only", 32'(leds), 32'hF);
    // Same-cycle write and read returns the old value.
    expect_rd(32'hF, "rw_same_cycle", 32'hFFFF_FFFF);
    op(A_LEDS, 32'hA, 4'hF, 1'b1);
    check("leds_after_rw", 32'(leds), 32'hA);
    rd(A_LEDS, 32'hA, "leds_rd2");
    wr(6'd6, 32'hFFFF_FFFF);
    rd(6'd6,  32'h0, "unmapped6");
    rd(6'd10, 32'h0, "unmapped10");

    // Timer wrap.
    wr(A_TIMER, 32'hFE);
    rd(A_TIMER, 32'hFE, "timer_written");
    rd(A_TIMER, 32'hFF, "timer_ff");
    rd(A_TIMER, 32'h00, "timer_wrap");

    // Timer compare: TIMER=90 written at edge B, match seen on edge B+11.
    wr(A_TCMP,   32'd100);
    wr(A_TIMER,  32'd90);
    wr(A_IRQ_EN, 32'h1);
    wr(A_STATUS, 32'h1);
    idle(7);
    rd(A_STATUS, 32'h0, "tmatch_before");
    check("irq_before1", 32'(irq), 32'h0);
    rd(A_STATUS, 32'h0, "tmatch_edge");
    check("irq_before2", 32'(irq), 32'h0);
    rd(A_STATUS, 32'h1, "tmatch_set");
    check("irq_set", 32'(irq), 32'h1);
    wr(A_STATUS, 32'h1);
    check("irq_lag", 32'(irq), 32'h1);
    idle(1);
    check("irq_cleared", 32'(irq), 32'h0);
    rd(A_STATUS, 32'h0, "tmatch_cleared");

    // Clear coinciding with a match: set wins.
    wr(A_TIMER, 32'd97);
    idle(3);
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, 32'h1, "set_wins");
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, 32'h0, "clear_after_set_wins");

    wr(A_IRQ_EN, 32'hFFFF_FFFF);
    rd(A_IRQ_EN, 32'h1FF, "irq_en_width");
    wr(A_IRQ_EN, 32'h100);

    // Seven-segment digits.
    wr(A_SEG0, 32'h8A);
`ifdef IO_HEX_DECODE_EN
    check("seg0_hex_A", 32'(seg[6:0]), 32'h08);
    rd(A_SEG0, 32'h8A, "seg0_rd_hex");
`else
    check("seg0_raw", 32'(seg[6:0]), 32'h0A);
    rd(A_SEG0, 32'h0A, "seg0_rd_nobit7");
`endif
    wr(A_SEG0, 32'h0A);
    check("seg0_raw0A", 32'(seg[6:0]), 32'h0A);
    rd(A_SEG0, 32'h0A, "seg0_rd_raw");
    wr(A_SEG1, 32'h3F00, 4'b0010);
    check("seg1_lane_ignored", 32'(seg[13:7]), 32'h7F);
    wr(A_SEG1, 32'h35);
    check("seg1_raw", 32'(seg[13:7]), 32'h35);

    // Debounce: a 5-cycle glitch is rejected.
    @(negedge clk);
    sw_in = 1'b1;
    idle(5);
    @(negedge clk);
    sw_in = 1'b0;
    idle(14);
    rd(A_SW, 32'h0, "glitch_sw");
    rd(A_STATUS, 32'h0, "glitch_swchg", 32'h100);
    check("glitch_irq", 32'(irq), 32'h0);

    // Reset mid-count, then full re-qualification with the pin held high.
    rd(A_LEDS, 32'hA, "leds_pre_reset");
    @(negedge clk);
    sw_in = 1'b1;
    idle(6);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_leds",  32'(leds), 32'h0);
    check("midrst_seg",   32'(seg),  32'h3FFF);
    check("midrst_rdata", io_rdata,  32'h0);
    check("midrst_irq",   32'(irq),  32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    idle(8);
    rd(A_SW, 32'h0, "sw_not_yet");
    rd(A_SW, 32'h1, "sw_accepted");
    rd(A_STATUS, 32'h100, "swchg_set", 32'h100);
    wr(A_IRQ_EN, 32'h100);
    idle(1);
    check("sw_irq", 32'(irq), 32'h1);
    wr(A_STATUS, 32'h100, 4'b0010);
    idle(1);
    check("sw_irq_cleared", 32'(irq), 32'h0);
    rd(A_STATUS, 32'h0, "swchg_cleared", 32'h100);

    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending reads, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
